// File: rtl/transfer_commit.sv
// transfer_commit: moves amount from sender to receiver balance in player RAM, committing both words only if no error applies.
module transfer_commit #(
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] sender_addr,
  input  logic [ADDR_W-1:0] receiver_addr,
  input  logic [7:0]        amount,
  input  logic [10:0]       memory_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic [10:0]       mem_data_in,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error_code
);
  typedef enum logic [3:0] {IDLE, RD_S, CAP_S, RD_R, CAP_R, CHECK, WR_S, WR_R, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] snd_q, snd_d, rcv_q, rcv_d, mem_address_q, mem_address_d;
  logic [7:0] amt_q, amt_d;
  logic [10:0] sw_q, sw_d, rw_q, rw_d, mem_data_in_q, mem_data_in_d;
  logic mem_wren_q, mem_wren_d, busy_q, busy_d, done_q, done_d;
  logic [1:0] error_code_q, error_code_d, err;
  logic [8:0] sum;
  always_comb begin
    snd_d = snd_q;
    rcv_d = rcv_q;
    amt_d = amt_q;
    sw_d = sw_q;
    rw_d = rw_q;
    state_d = state_q;
    sum = {1'b0, rw_q[7:0]} + {1'b0, amt_q};
    err = (snd_q == rcv_q) ? 2'b11 : (sw_q[7:0] < amt_q) ? 2'b01 : sum[8] ? 2'b10 : 2'b00;
    case (state_q)
      IDLE: if (start) begin
        snd_d = sender_addr;
        rcv_d = receiver_addr;
        amt_d = amount;
        state_d = RD_S;
      end
      RD_S:  state_d = CAP_S;
      CAP_S: begin sw_d = memory_out; state_d = RD_R; end
      RD_R:  state_d = CAP_R;
      CAP_R: begin rw_d = memory_out; state_d = CHECK; end
      CHECK: state_d = (err != 2'b00) ? FIN : WR_S;
      WR_S:  state_d = WR_R;
      WR_R:  state_d = FIN;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are decoded from the state being entered
    mem_wren_d = (state_d == WR_S) || (state_d == WR_R);
    mem_address_d = (state_d inside {RD_S, CAP_S, WR_S}) ? snd_d :
                    (state_d inside {RD_R, CAP_R, WR_R}) ? rcv_d : '0;
    mem_data_in_d = (state_d == WR_S) ? {sw_d[10:8], sw_d[7:0] - amt_d} :
                    (state_d == WR_R) ? {rw_d[10:8], sum[7:0]} : 11'd0;
    busy_d = state_d != IDLE;
    done_d = state_d == FIN;
    error_code_d = (state_q == CHECK && state_d == FIN) ? err : 2'b00;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      snd_q <= '0;
      rcv_q <= '0;
      amt_q <= '0;
      sw_q <= '0;
      rw_q <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_wren_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_code_q <= 2'b00;
    end else begin
      state_q <= state_d;
      snd_q <= snd_d;
      rcv_q <= rcv_d;
      amt_q <= amt_d;
      sw_q <= sw_d;
      rw_q <= rw_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_wren_q <= mem_wren_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_code_q <= error_code_d;
    end
  end
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_wren = mem_wren_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error_code = error_code_q;
endmodule
